sdram_pattern_checker: RTL and testbench

SDRAM_PATTERN_CHECKER -- requirements
Module: sdram_pattern_checker

---
 rtl/sdram_test_pkg.sv | 18 +
 rtl/sdram_pattern_gen.sv | 20 ++
 rtl/sdram_pattern_checker.sv | 153 +++++++++++++++
 tb/tb_sdram_pattern_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// Purpose: shared state encodings and pattern-select codes for the SDRAM pattern checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // pat_sel codes: the word index itself, or its bitwise inverse
    localparam logic PAT_INDEX  = 1'b0;
    localparam logic PAT_INVERT = 1'b1;

endpackage

// File: rtl/sdram_pattern_gen.sv
// Purpose: test data for a word index (index or inverted index, zero-extended to 16 bits).
// Latency: combinational.
// Backpressure: none.
// Ports: idx (word index), pat_sel (pattern code), data (16-bit pattern word).
module sdram_pattern_gen
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic              pat_sel,
    output logic [15:0]       data
);

    logic [15:0] idx_ext;

    assign idx_ext = 16'(idx);
    assign data    = (pat_sel == PAT_INVERT) ? ~idx_ext : idx_ext;

endmodule

// File: rtl/sdram_pattern_checker.sv
// Purpose: writes a pattern to 2^ADDR_W SDRAM words, reads them back and counts mismatches.
// Latency: one request per access slot; run ends 2*2^ADDR_W+1 slots after the first slot.
// Backpressure: paced entirely by slot_en rising edges; start is ignored while busy.
// Ports: clk_cpu/reset; start, pat_sel control; slot_en slot strobe; mem_* controller CPU port;
//        busy/done/pass status; err_count, first_err_addr, first_err_data results.
module sdram_pattern_checker
    import sdram_test_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        start,
    input  logic        pat_sel,
    input  logic        slot_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_ds,
    input  logic [15:0] mem_dout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [23:0] first_err_addr,
    output logic [15:0] first_err_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state, state_nxt;
    logic              slot_en_d;
    logic              slot_rise;
    logic              pat_lat;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rd_idx;      // index of the read whose data arrives next slot
    logic              rd_pending;
    logic [15:0]       wr_pat;
    logic [15:0]       cmp_pat;
    logic              start_ok;
    logic              issue;
    logic              compare;
    logic              mismatch;

    assign slot_rise = slot_en & ~slot_en_d;
    assign mem_ds    = 2'b11;
    assign busy      = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign pass      = done && (err_count == 16'h0000);

    sdram_pattern_gen #(.ADDR_W(ADDR_W)) u_gen_wr (
        .idx     (idx),
        .pat_sel (pat_lat),
        .data    (wr_pat)
    );

    sdram_pattern_gen #(.ADDR_W(ADDR_W)) u_gen_cmp (
        .idx     (rd_idx),
        .pat_sel (pat_lat),
        .data    (cmp_pat)
    );

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        issue     = 1'b0;
        compare   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (slot_rise) begin
                    issue = 1'b1;
                    if (idx == LAST_IDX) state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (slot_rise) begin
                    issue   = 1'b1;
                    // data for the previous slot's read is valid on this rise
                    compare = rd_pending;
                    if (idx == LAST_IDX) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (slot_rise) begin
                    compare   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        mismatch = compare && (mem_dout != cmp_pat);
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            slot_en_d      <= 1'b0;
            pat_lat        <= PAT_INDEX;
            idx            <= '0;
            rd_idx         <= '0;
            rd_pending     <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 24'h000000;
            mem_din        <= 16'h0000;
            err_count      <= 16'h0000;
            first_err_addr <= 24'h000000;
            first_err_data <= 16'h0000;
        end else begin
            slot_en_d <= slot_en;
            mem_req   <= issue;
            if (start_ok) begin
                idx            <= '0;
                rd_pending     <= 1'b0;
                pat_lat        <= pat_sel;
                err_count      <= 16'h0000;
                first_err_addr <= 24'h000000;
                first_err_data <= 16'h0000;
            end
            if (issue) begin
                mem_we   <= (state == ST_WRITE);
                mem_addr <= BASE_ADDR + 24'(idx);
                mem_din  <= wr_pat;
                // wraps to 0 after the last write, which is where reads begin
                idx      <= idx + ADDR_W'(1);
                if (state == ST_READ) begin
                    rd_idx     <= idx;
                    rd_pending <= 1'b1;
                end
            end
            if (mismatch) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'h0000) begin
                    first_err_addr <= BASE_ADDR + 24'(rd_idx);
                    first_err_data <= mem_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_pattern_checker.sv
// Purpose: self-checking bench for sdram_pattern_checker with a one-slot-latency memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_pattern_checker;

    localparam int          AW   = 4;
    localparam int          NW   = 16;
    localparam logic [23:0] BASE = 24'hFFFFF8;

    logic        clk_cpu;
    logic        reset;
    logic        start;
    logic        pat_sel;
    logic        slot_en;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_ds;
    logic [15:0] mem_dout;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;
    logic [15:0] first_err_data;

    sdram_pattern_checker #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk_cpu        (clk_cpu),
        .reset          (reset),
        .start          (start),
        .pat_sel        (pat_sel),
        .slot_en        (slot_en),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_ds         (mem_ds),
        .mem_dout       (mem_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .first_err_data (first_err_data)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_pat(input int i, input logic p);
        logic [15:0] v;
        v = 16'(i);
        return p ? ~v : v;
    endfunction

    // memory model: mode 0 ideal, 1 corrupts address 5 to 0000, 2 returns DEAD
    logic        model_clr = 1'b0;
    logic        cur_pat   = 1'b0;
    int          mode      = 0;
    int          wr_cnt, rd_cnt, req_cnt, wr_bad, addr_bad;
    logic [15:0] mem [NW];
    logic [23:0] wr_addr_log [NW];

    always @(negedge clk_cpu) begin
        if (model_clr) begin
            wr_cnt = 0; rd_cnt = 0; req_cnt = 0; wr_bad = 0; addr_bad = 0;
            mem_dout = 16'h0000;
            for (int i = 0; i < NW; i++) wr_addr_log[i] = 24'hxxxxxx;
        end else if (mem_req === 1'b1) begin
            req_cnt++;
            if (mem_we) begin
                if (mem_addr !== BASE + 24'(wr_cnt)) addr_bad++;
                if (mem_din !== exp_pat(wr_cnt % NW, cur_pat)) wr_bad++;
                if (wr_cnt < NW) wr_addr_log[wr_cnt] = mem_addr;
                mem[mem_addr[3:0]] = mem_din;
                wr_cnt++;
            end else begin
                if (mem_addr !== BASE + 24'(rd_cnt)) addr_bad++;
                case (mode)
                    1:       mem_dout = (mem_addr == 24'h000005) ? 16'h0000 : mem[mem_addr[3:0]];
                    2:       mem_dout = 16'hDEAD;
                    default: mem_dout = mem[mem_addr[3:0]];
                endcase
                rd_cnt++;
            end
        end
    end

    // all tasks start and end one time unit after a rising edge
    task automatic clear_model();
        model_clr = 1'b1;
        @(negedge clk_cpu); #1;
        model_clr = 1'b0;
        @(posedge clk_cpu); #1;
    endtask

    task automatic pulse_start(input logic p);
        start   = 1'b1;
        pat_sel = p;
        @(posedge clk_cpu); #1;
        start   = 1'b0;
        pat_sel = ~p;
    endtask

    task automatic slot();
        slot_en = 1'b1;
        @(posedge clk_cpu); #1;
        @(posedge clk_cpu); #1;
        slot_en = 1'b0;
        @(posedge clk_cpu); #1;
        @(posedge clk_cpu); #1;
    endtask

    task automatic run(input logic p, input int md, input int start_at, input int long_at,
                       output int slots);
        int r0;
        cur_pat = p;
        mode    = md;
        clear_model();
        pulse_start(p);
        slots = 0;
        while (done !== 1'b1 && slots < 40) begin
            if (slots == start_at) pulse_start(~p);
            if (slots == long_at) begin
                r0 = req_cnt;
                slot_en = 1'b1;
                repeat (10) @(posedge clk_cpu);
                #1 slot_en = 1'b0;
                @(posedge clk_cpu); #1;
                @(posedge clk_cpu); #1;
                check("long_slot_reqs", 32'(req_cnt - r0), 32'd1);
            end else begin
                slot();
            end
            slots++;
        end
    endtask

    typedef struct {
        logic        pat;
        int          mode;
        int          exp_err;
        logic        exp_pass;
        logic [23:0] exp_faddr;
        logic [15:0] exp_fdata;
    } vec_t;

    vec_t vecs [5];
    int   slots;
    int   r0;

    initial begin
        vecs[0] = '{1'b0, 0, 0,  1'b1, 24'h000000, 16'h0000};
        vecs[1] = '{1'b0, 1, 1,  1'b0, 24'h000005, 16'h0000};
        vecs[2] = '{1'b1, 0, 0,  1'b1, 24'h000000, 16'h0000};
        vecs[3] = '{1'b0, 2, 16, 1'b0, 24'hFFFFF8, 16'hDEAD};
        vecs[4] = '{1'b1, 2, 16, 1'b0, 24'hFFFFF8, 16'hDEAD};

        reset = 1'b1; start = 1'b0; pat_sel = 1'b0; slot_en = 1'b0;
        repeat (3) @(posedge clk_cpu);
        #1;
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_we",    32'(mem_we), 32'd0);
        check("rst_mem_addr",  32'(mem_addr), 32'd0);
        check("rst_mem_din",   32'(mem_din), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_done",      32'(done), 32'd0);
        check("rst_pass",      32'(pass), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_ferr_addr", 32'(first_err_addr), 32'd0);
        check("rst_ferr_data", 32'(first_err_data), 32'd0);
        reset = 1'b0;
        @(posedge clk_cpu); #1;

        for (int v = 0; v < 5; v++) begin
            run(vecs[v].pat, vecs[v].mode, -1, -1, slots);
            check($sformatf("v%0d_slots", v),     32'(slots), 32'd33);
            check($sformatf("v%0d_done", v),      32'(done), 32'd1);
            check($sformatf("v%0d_busy", v),      32'(busy), 32'd0);
            check($sformatf("v%0d_pass", v),      32'(pass), 32'(vecs[v].exp_pass));
            check($sformatf("v%0d_err_count", v), 32'(err_count), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_ferr_addr", v), 32'(first_err_addr), 32'(vecs[v].exp_faddr));
            check($sformatf("v%0d_ferr_data", v), 32'(first_err_data), 32'(vecs[v].exp_fdata));
            check($sformatf("v%0d_writes", v),    32'(wr_cnt), 32'd16);
            check($sformatf("v%0d_reads", v),     32'(rd_cnt), 32'd16);
            check($sformatf("v%0d_wr_data", v),   32'(wr_bad), 32'd0);
            check($sformatf("v%0d_addr_seq", v),  32'(addr_bad), 32'd0);
            check($sformatf("v%0d_addr_first", v), 32'(wr_addr_log[0]), 32'hFFFFF8);
            check($sformatf("v%0d_addr_wrap", v), 32'(wr_addr_log[8]), 32'h000000);
            check($sformatf("v%0d_mem_ds", v),    32'(mem_ds), 32'd3);
            slot();
            check($sformatf("v%0d_no_req_done", v), 32'(req_cnt), 32'd32);
            check($sformatf("v%0d_done_held", v),   32'(done), 32'd1);
        end

        // start pulsed mid-run (with opposite pat_sel) and a 10-cycle slot_en
        run(1'b0, 0, 5, 3, slots);
        check("busy_start_slots",  32'(slots), 32'd33);
        check("busy_start_writes", 32'(wr_cnt), 32'd16);
        check("busy_start_wrdata", 32'(wr_bad), 32'd0);
        check("busy_start_pass",   32'(pass), 32'd1);

        // reset while reading idx 7, coinciding with a slot rise
        cur_pat = 1'b0;
        mode    = 0;
        clear_model();
        pulse_start(1'b0);
        for (int s = 0; s < NW + 7; s++) slot();
        check("pre_reset_reads", 32'(rd_cnt), 32'd7);
        slot_en = 1'b1;
        reset   = 1'b1;
        @(posedge clk_cpu); #1;
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_busy",    32'(busy), 32'd0);
        r0    = req_cnt;
        reset = 1'b0;
        repeat (4) @(posedge clk_cpu);
        #1 slot_en = 1'b0;
        repeat (4) @(posedge clk_cpu);
        #1;
        check("post_rst_no_req",   32'(req_cnt - r0), 32'd0);
        check("post_rst_done",     32'(done), 32'd0);
        check("post_rst_err_cnt",  32'(err_count), 32'd0);
        run(1'b0, 0, -1, -1, slots);
        check("rerun_slots", 32'(slots), 32'd33);
        check("rerun_pass",  32'(pass), 32'd1);
        check("rerun_errs",  32'(err_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
